// File: rtl/aes256_rk_sched_ctrl.sv
// Purpose : AES-256 key-expansion controller and 15-entry round-key store.
// Latency : key accept -> keys_ready after 15 cycles with a back-to-back engine; round-key reads return 1 cycle after rk_req.
// Backpr. : key_ready is low while an expansion is in flight; reads are never stalled and may issue every cycle.
//
// Ports:
//   clk, reset_n                   clock, async active-low reset
//   key_valid/key_ready/key_in     256-bit cipher key handshake
//   exp_start/exp_key              start pulse and held key to the expansion engine
//   exp_subkey/exp_valid           subkey stream from the engine (rounds 2..NR)
//   rk_req/rk_idx                  round-key read request
//   rk_valid/rk_data/rk_err        read response (data forced to 0 on error)
//   keys_ready                     all NR+1 round keys are valid
//   exp_err                        one-cycle pulse when the engine stalls mid-stream
module aes256_rk_sched_ctrl #(
  parameter int NR      = 14,
  parameter int EXP_GEN = 13
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [255:0] key_in,
  output logic         exp_start,
  output logic [255:0] exp_key,
  input  logic [127:0] exp_subkey,
  input  logic         exp_valid,
  input  logic         rk_req,
  input  logic [3:0]   rk_idx,
  output logic         rk_valid,
  output logic [127:0] rk_data,
  output logic         rk_err,
  output logic         keys_ready,
  output logic         exp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_COLLECT,
    S_READY
  } state_t;

  localparam logic [3:0] LAST_IDX  = 4'(NR);
  // Rounds 0 and 1 come straight from the key; the engine fills the rest.
  localparam logic [3:0] FIRST_GEN = 4'(NR - EXP_GEN + 1);

  state_t       state;
  logic [3:0]   count;
  logic         lat_slot;  // first COLLECT cycle: engine may still be idle
  logic [127:0] store [0:NR];

  logic accept;
  logic capture;

  assign accept  = key_valid & key_ready;
  assign capture = (state == S_COLLECT) & exp_valid;

  // Round-key storage carries no reset; keys_ready gates every read.
  always_ff @(posedge clk) begin
    if (accept) begin
      store[0] <= key_in[255:128];
      store[1] <= key_in[127:0];
    end
    if (capture) begin
      store[count] <= exp_subkey;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      count      <= 4'd0;
      lat_slot   <= 1'b0;
      key_ready  <= 1'b1;
      exp_start  <= 1'b0;
      exp_key    <= '0;
      keys_ready <= 1'b0;
      exp_err    <= 1'b0;
      rk_valid   <= 1'b0;
      rk_err     <= 1'b0;
      rk_data    <= '0;
    end else begin
      exp_start <= 1'b0;
      exp_err   <= 1'b0;

      // Reads see the keys_ready/store values from before any same-cycle
      // key accept, so an in-flight read completes with the old key.
      rk_valid <= rk_req;
      if (rk_req) begin
        if (keys_ready && (rk_idx <= LAST_IDX)) begin
          rk_data <= store[rk_idx];
          rk_err  <= 1'b0;
        end else begin
          rk_data <= '0;
          rk_err  <= 1'b1;
        end
      end else begin
        rk_err <= 1'b0;
      end

      case (state)
        S_IDLE, S_READY: begin
          if (accept) begin
            exp_key    <= key_in;
            keys_ready <= 1'b0;
            key_ready  <= 1'b0;
            exp_start  <= 1'b1;
            state      <= S_START;
          end
        end

        S_START: begin
          count    <= FIRST_GEN;
          lat_slot <= 1'b1;
          state    <= S_COLLECT;
        end

        S_COLLECT: begin
          lat_slot <= 1'b0;
          if (exp_valid) begin
            count <= count + 4'd1;
            if (count == LAST_IDX) begin
              keys_ready <= 1'b1;
              key_ready  <= 1'b1;
              state      <= S_READY;
            end
          end else if (!lat_slot) begin
            // Engine broke the consecutive-subkey stream: abandon the key.
            exp_err   <= 1'b1;
            key_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          key_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes256_rk_sched_ctrl.sv
module tb_aes256_rk_sched_ctrl;

  localparam logic [255:0] FIPS_KEY =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] FIPS_RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] FIPS_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;
  localparam logic [127:0] ZERO_RK2  = 128'h62636363626363636263636362636363;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [255:0] key_in = '0;
  logic         exp_start;
  logic [255:0] exp_key;
  logic [127:0] exp_subkey = '0;
  logic         exp_valid = 1'b0;
  logic         rk_req = 1'b0;
  logic [3:0]   rk_idx = 4'd0;
  logic         rk_valid;
  logic [127:0] rk_data;
  logic         rk_err;
  logic         keys_ready;
  logic         exp_err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  aes256_rk_sched_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_in     (key_in),
    .exp_start  (exp_start),
    .exp_key    (exp_key),
    .exp_subkey (exp_subkey),
    .exp_valid  (exp_valid),
    .rk_req     (rk_req),
    .rk_idx     (rk_idx),
    .rk_valid   (rk_valid),
    .rk_data    (rk_data),
    .rk_err     (rk_err),
    .keys_ready (keys_ready),
    .exp_err    (exp_err)
  );

  // Engine model subkeys: known FIPS-197 values where given, otherwise a
  // tagged pattern so every stored round is distinguishable.
  function automatic logic [127:0] subkey_of(input logic [255:0] k, input int r);
    if (k == FIPS_KEY && r == 2)  return FIPS_RK2;
    if (k == FIPS_KEY && r == 14) return FIPS_RK14;
    if (k == '0 && r == 2)        return ZERO_RK2;
    return {k[255:224] ^ 32'(r), 32'h5a5a0000 | 32'(r), k[95:64], 32'(r * 7)};
  endfunction

  // Engine model: idle during START, then one subkey per cycle, optionally
  // stopping after eng_limit subkeys.
  int eng_limit  = 13;
  int eng_r      = 0;
  bit eng_active = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      eng_active = 1'b0;
      exp_valid  = 1'b0;
    end else begin
      if (eng_active && eng_r <= 14 && (eng_r - 2) < eng_limit) begin
        exp_valid  = 1'b1;
        exp_subkey = subkey_of(exp_key, eng_r);
        eng_r++;
      end else begin
        exp_valid  = 1'b0;
        eng_active = 1'b0;
      end
      if (exp_start) begin
        eng_active = 1'b1;
        eng_r      = 2;
      end
    end
  end

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  // Bounded wait for keys_ready; counts cycles, start pulses and any cycle
  // where key_ready was offered while an expansion was still running.
  task automatic wait_ready(input bit hold, output int cyc, output int starts, output int busy_rdy);
    cyc = 0; starts = 0; busy_rdy = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cyc++;
      if (!hold) key_valid = 1'b0;
      if (exp_start) starts++;
      if (keys_ready) break;
      if (key_ready) busy_rdy++;
    end
  endtask

  task automatic read_rk(input logic [3:0] idx, input string nm, input bit e_err, input logic [127:0] e_data);
    rk_idx = idx;
    rk_req = 1'b1;
    @(negedge clk);
    rk_req = 1'b0;
    check({nm, "_vld"},  rk_valid, 1);
    check({nm, "_err"},  rk_err,   e_err);
    check({nm, "_data"}, rk_data,  e_data);
  endtask

  typedef struct {
    logic [3:0]   idx;
    bit           err;
    logic [127:0] data;
    string        name;
  } rd_vec_t;

  rd_vec_t rv [7];

  initial begin
    int cyc, starts, busy, pulses;
    logic [255:0] fk;
    fk = FIPS_KEY;

    rv[0] = '{4'd0,  1'b0, fk[255:128],            "tbl_idx0"};
    rv[1] = '{4'd1,  1'b0, fk[127:0],              "tbl_idx1"};
    rv[2] = '{4'd2,  1'b0, FIPS_RK2,               "tbl_idx2"};
    rv[3] = '{4'd15, 1'b1, 128'h0,                 "tbl_idx15"};
    rv[4] = '{4'd14, 1'b0, FIPS_RK14,              "tbl_idx14"};
    rv[5] = '{4'd7,  1'b0, subkey_of(FIPS_KEY, 7), "tbl_idx7"};
    rv[6] = '{4'd3,  1'b0, subkey_of(FIPS_KEY, 3), "tbl_idx3"};

    // Reset state
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_keys_ready", keys_ready, 0);
    check("rst_key_ready",  key_ready,  1);
    check("rst_rk_valid",   rk_valid,   0);
    check("rst_rk_err",     rk_err,     0);
    check("rst_rk_data",    rk_data,    0);
    check("rst_exp_start",  exp_start,  0);
    check("rst_exp_key",    exp_key,    0);
    check("rst_exp_err",    exp_err,    0);
    reset_n = 1'b1;
    @(negedge clk);

    // Read before any key is loaded
    read_rk(4'd3, "rd_not_ready", 1'b1, 128'h0);

    // FIPS key, one-cycle key_valid
    key_in = FIPS_KEY; key_valid = 1'b1;
    wait_ready(1'b0, cyc, starts, busy);
    check("fips_keys_ready", keys_ready, 1);
    check("fips_latency",    cyc,        15);
    check("fips_starts",     starts,     1);
    check("fips_busy_rdy",   busy,       0);
    check("fips_exp_key",    exp_key,    FIPS_KEY);

    // Table of back-to-back reads
    for (int i = 0; i < 7; i++) begin
      rk_idx = rv[i].idx;
      rk_req = 1'b1;
      @(negedge clk);
      check({rv[i].name, "_vld"},  rk_valid, 1);
      check({rv[i].name, "_err"},  rk_err,   rv[i].err);
      check({rv[i].name, "_data"}, rk_data,  rv[i].data);
    end
    rk_req = 1'b0;
    @(negedge clk);
    check("idle_rk_valid", rk_valid, 0);
    check("idle_rk_err",   rk_err,   0);
    check("idle_rk_hold",  rk_data,  rv[6].data);

    // Engine drops exp_valid after 5 subkeys
    eng_limit = 5;
    key_in = FIPS_KEY; key_valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      key_valid = 1'b0;
      if (exp_err) pulses++;
    end
    check("drop_err_pulses", pulses,     1);
    check("drop_keys_ready", keys_ready, 0);
    check("drop_key_ready",  key_ready,  1);
    read_rk(4'd2, "drop_rd", 1'b1, 128'h0);
    eng_limit = 13;

    // Async reset in the middle of COLLECT
    key_in = FIPS_KEY; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (5) @(negedge clk);
    rk_idx = 4'd0; rk_req = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_rk_valid", rk_valid, 1);
    check("pre_rst_rk_err",   rk_err,   1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_keys_ready", keys_ready, 0);
    check("mid_rst_rk_valid",   rk_valid,   0);
    check("mid_rst_exp_key",    exp_key,    0);
    check("mid_rst_key_ready",  key_ready,  1);
    @(negedge clk);
    rk_req = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    key_in = FIPS_KEY; key_valid = 1'b1;
    wait_ready(1'b0, cyc, starts, busy);
    check("reload_keys_ready", keys_ready, 1);
    check("reload_latency",    cyc,        15);
    read_rk(4'd14, "reload_idx14", 1'b0, FIPS_RK14);

    // Re-key with zero key while reading idx 14 in the accept cycle
    key_in = '0; key_valid = 1'b1;
    rk_idx = 4'd14; rk_req = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; rk_req = 1'b0;
    check("rekey_rd_vld",     rk_valid,   1);
    check("rekey_rd_err",     rk_err,     0);
    check("rekey_rd_data",    rk_data,    FIPS_RK14);
    check("rekey_keys_ready", keys_ready, 0);
    check("rekey_exp_start",  exp_start,  1);
    wait_ready(1'b0, cyc, starts, busy);
    check("zero_keys_ready", keys_ready, 1);
    check("zero_latency",    cyc,        14);
    read_rk(4'd2, "zero_idx2", 1'b0, ZERO_RK2);
    read_rk(4'd0, "zero_idx0", 1'b0, 128'h0);

    // key_valid held high across a whole expansion
    key_in = FIPS_KEY; key_valid = 1'b1;
    wait_ready(1'b1, cyc, starts, busy);
    check("hold_keys_ready", keys_ready, 1);
    check("hold_starts",     starts,     1);
    check("hold_busy_rdy",   busy,       0);
    @(negedge clk);
    key_valid = 1'b0;
    check("hold_reaccept_keys_ready", keys_ready, 0);
    check("hold_reaccept_start",      exp_start,  1);
    wait_ready(1'b0, cyc, starts, busy);
    check("hold_final_ready", keys_ready, 1);
    read_rk(4'd1, "hold_idx1", 1'b0, fk[127:0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
